// File: rtl/mem_wb_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_unit
// Brief    : Memory-access and write-back stage of the 5-stage pipeline.
//            Issues loads and stores to a wait-stated data memory over a
//            req/ack handshake. Freezes upstream stages while an access is
//            outstanding. Drives the register-file write port.
// Options  : MEM_TIMEOUT_EN - abort a WAIT that lasts TIMEOUT_CYCLES cycles
//            without an ack, and pulse mem_err.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_unit #(
    parameter int ADDR_BASE      = 1024,
    parameter int MEM_ADDR_W     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  WB_EN_in,
    input  logic                  MEM_R_EN_in,
    input  logic                  MEM_W_EN_in,
    input  logic [31:0]           ALU_Res,
    input  logic [31:0]           Val_Rm,
    input  logic [3:0]            Dest_in,
    output logic                  freeze,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           Result_WB,
    output logic                  writeBackEn,
    output logic [3:0]            Dest_wb,
    output logic                  mem_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] c_ADDR_BASE = 32'(ADDR_BASE);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_wb_en;
    logic [3:0]              r_dest;
    logic                    w_mem_in;
    logic                    w_timeout;
    logic                    w_done;
    logic [31:0]             w_offset;
    logic [MEM_ADDR_W-1:0]   w_word_addr;
    logic                    w_unused;

    // A zero timeout would make every access abort before it could be acked.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("mem_wb_unit: TIMEOUT_CYCLES must be at least 1");
    end

    // Byte address to word address; underflow wraps, low two bits dropped.
    assign w_offset    = ALU_Res - c_ADDR_BASE;
    assign w_word_addr = w_offset[MEM_ADDR_W+1:2];
    assign w_unused    = ^w_offset;

    assign w_mem_in = MEM_R_EN_in | MEM_W_EN_in;
    assign w_done   = mem_ack | w_timeout;

`ifdef MEM_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_mem_err;

    // Timeout fires in the last permitted WAIT cycle; a coincident ack wins.
    assign w_timeout = (r_state == S_WAIT) && (r_wait_cnt == c_CNT_LAST) && !mem_ack;

    // WAIT-cycle counter (held at zero in IDLE) and one-cycle abort pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_mem_err <= w_timeout;
            if (r_state == S_IDLE) begin
                r_wait_cnt <= '0;
            end else if (!mem_ack) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end
        end
    end

    assign mem_err = r_mem_err;
`else
    assign w_timeout = 1'b0;
    assign mem_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and freeze; freeze drops in the completing cycle so the
    // upstream registers advance on the same edge the access retires.
    always_comb begin
        w_state_nxt = r_state;
        freeze      = 1'b0;
        case (r_state)
            S_IDLE: begin
                freeze = w_mem_in;
                if (w_mem_in) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                freeze = ~w_done;
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory request registers, latched instruction info and WB register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            r_wb_en     <= 1'b0;
            r_dest      <= '0;
            Result_WB   <= '0;
            writeBackEn <= 1'b0;
            Dest_wb     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_in) begin
                        // A load takes priority when both enables are set.
                        mem_req     <= 1'b1;
                        mem_we      <= MEM_W_EN_in & ~MEM_R_EN_in;
                        mem_addr    <= w_word_addr;
                        mem_wdata   <= Val_Rm;
                        r_wb_en     <= WB_EN_in;
                        r_dest      <= Dest_in;
                        writeBackEn <= 1'b0;
                    end else begin
                        Result_WB   <= ALU_Res;
                        writeBackEn <= WB_EN_in;
                        Dest_wb     <= Dest_in;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            Result_WB   <= mem_rdata;
                            writeBackEn <= r_wb_en;
                            Dest_wb     <= r_dest;
                        end else begin
                            writeBackEn <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        // Aborted load returns zero; aborted store writes nothing.
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            Result_WB   <= 32'h0;
                            writeBackEn <= r_wb_en;
                            Dest_wb     <= r_dest;
                        end else begin
                            writeBackEn <= 1'b0;
                        end
                    end else begin
                        writeBackEn <= 1'b0;
                    end
                end
                default: begin
                    mem_req     <= 1'b0;
                    writeBackEn <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_unit
// Brief    : Directed self-checking bench for mem_wb_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        WB_EN_in = 1'b0;
    logic        MEM_R_EN_in = 1'b0;
    logic        MEM_W_EN_in = 1'b0;
    logic [31:0] ALU_Res = '0;
    logic [31:0] Val_Rm = '0;
    logic [3:0]  Dest_in = '0;
    logic        freeze;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] Result_WB;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_wb_unit #(
        .ADDR_BASE      (1024),
        .MEM_ADDR_W     (16),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .WB_EN_in    (WB_EN_in),
        .MEM_R_EN_in (MEM_R_EN_in),
        .MEM_W_EN_in (MEM_W_EN_in),
        .ALU_Res     (ALU_Res),
        .Val_Rm      (Val_Rm),
        .Dest_in     (Dest_in),
        .freeze      (freeze),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .Result_WB   (Result_WB),
        .writeBackEn (writeBackEn),
        .Dest_wb     (Dest_wb),
        .mem_err     (mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic set_in(input logic wb, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] d);
        WB_EN_in = wb; MEM_R_EN_in = rd; MEM_W_EN_in = wr;
        ALU_Res = alu; Val_Rm = rm; Dest_in = d;
    endtask

    task automatic bubble();
        set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Advance past the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Sample point, half a cycle away from the active edge.
    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        tick(); tick(); mid();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", mem_req); end
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL rst_wben: got %b want 0", writeBackEn); end
        checks++; if (Result_WB !== 32'h0) begin errors++; $display("FAIL rst_result: got %h want 0", Result_WB); end
        checks++; if (Dest_wb !== 4'h0) begin errors++; $display("FAIL rst_dest: got %h want 0", Dest_wb); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze: got %b want 0", freeze); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", mem_err); end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_add();
        set_in(1'b1, 1'b0, 1'b0, 32'h0000_0055, 32'h0, 4'd3);
        mid();
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL add_freeze: got %b want 0", freeze); end
        tick(); bubble(); mid();
        checks++; if (writeBackEn !== 1'b1) begin errors++; $display("FAIL add_wben: got %b want 1", writeBackEn); end
        checks++; if (Dest_wb !== 4'd3) begin errors++; $display("FAIL add_dest: got %h want 3", Dest_wb); end
        checks++; if (Result_WB !== 32'h55) begin errors++; $display("FAIL add_result: got %h want 55", Result_WB); end
        tick(); mid();
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL add_bubble_wben: got %b want 0", writeBackEn); end
        tick();
    endtask

    task automatic test_store();
        set_in(1'b0, 1'b0, 1'b1, 32'd1028, 32'hCAFE_0001, 4'd0);
        mid();
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL st_freeze0: got %b want 1", freeze); end
        tick();
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL st_req[%0d]: got %b want 1", i, mem_req); end
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL st_we[%0d]: got %b want 1", i, mem_we); end
            checks++; if (mem_addr !== 16'd1) begin errors++; $display("FAIL st_addr[%0d]: got %h want 1", i, mem_addr); end
            checks++; if (mem_wdata !== 32'hCAFE_0001) begin errors++; $display("FAIL st_wdata[%0d]: got %h want cafe0001", i, mem_wdata); end
            checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL st_freeze[%0d]: got %b want 1", i, freeze); end
            checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL st_wben[%0d]: got %b want 0", i, writeBackEn); end
            checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL st_err[%0d]: got %b want 0", i, mem_err); end
            tick();
        end
        mem_ack = 1'b1;
        mid();
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL st_ack_freeze: got %b want 0", freeze); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL st_ack_req: got %b want 1", mem_req); end
        tick(); mem_ack = 1'b0; bubble(); mid();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL st_done_req: got %b want 0", mem_req); end
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL st_done_wben: got %b want 0", writeBackEn); end
        tick();
    endtask

    task automatic test_load();
        set_in(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7);
        mid();
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL ld_freeze0: got %b want 1", freeze); end
        tick(); mem_ack = 1'b1; mem_rdata = 32'h1234_5678; mid();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ld_req: got %b want 1", mem_req); end
        checks++; if (mem_addr !== 16'd2) begin errors++; $display("FAIL ld_addr: got %h want 2", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL ld_we: got %b want 0", mem_we); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL ld_ack_freeze: got %b want 0", freeze); end
        tick(); mem_ack = 1'b0; mem_rdata = 32'h0; bubble(); mid();
        checks++; if (writeBackEn !== 1'b1) begin errors++; $display("FAIL ld_wben: got %b want 1", writeBackEn); end
        checks++; if (Dest_wb !== 4'd7) begin errors++; $display("FAIL ld_dest: got %h want 7", Dest_wb); end
        checks++; if (Result_WB !== 32'h1234_5678) begin errors++; $display("FAIL ld_result: got %h want 12345678", Result_WB); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ld_req_done: got %b want 0", mem_req); end
        tick(); mid();
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL ld_wben_once: got %b want 0", writeBackEn); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 1'b1, 1'b0, 32'd1036, 32'h0, 4'd9);
        mid();
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL b2b_freeze0: got %b want 1", freeze); end
        tick(); mem_ack = 1'b1; mem_rdata = 32'hA5A5_0009; mid();
        checks++; if (mem_addr !== 16'd3) begin errors++; $display("FAIL b2b_addr: got %h want 3", mem_addr); end
        tick();
        set_in(1'b1, 1'b0, 1'b0, 32'h0000_0077, 32'h0, 4'd4);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_EEEE;
        mid();
        checks++; if (writeBackEn !== 1'b1) begin errors++; $display("FAIL b2b_ld_wben: got %b want 1", writeBackEn); end
        checks++; if (Dest_wb !== 4'd9) begin errors++; $display("FAIL b2b_ld_dest: got %h want 9", Dest_wb); end
        checks++; if (Result_WB !== 32'hA5A5_0009) begin errors++; $display("FAIL b2b_ld_result: got %h want a5a50009", Result_WB); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL b2b_add_freeze: got %b want 0", freeze); end
        tick(); mem_ack = 1'b0; mem_rdata = 32'h0; bubble(); mid();
        checks++; if (writeBackEn !== 1'b1) begin errors++; $display("FAIL b2b_add_wben: got %b want 1", writeBackEn); end
        checks++; if (Dest_wb !== 4'd4) begin errors++; $display("FAIL b2b_add_dest: got %h want 4", Dest_wb); end
        checks++; if (Result_WB !== 32'h77) begin errors++; $display("FAIL b2b_add_result: got %h want 77", Result_WB); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL b2b_stray_req: got %b want 0", mem_req); end
        tick(); mid();
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL b2b_tail_wben: got %b want 0", writeBackEn); end
        tick();
    endtask

    task automatic test_priority();
        set_in(1'b1, 1'b1, 1'b1, 32'd1040, 32'h1111_2222, 4'd6);
        mid();
        checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL pri_freeze: got %b want 1", freeze); end
        tick(); mem_ack = 1'b1; mem_rdata = 32'h0000_BEEF; mid();
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL pri_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 16'd4) begin errors++; $display("FAIL pri_addr: got %h want 4", mem_addr); end
        tick(); mem_ack = 1'b0; mem_rdata = 32'h0; bubble(); mid();
        checks++; if (writeBackEn !== 1'b1) begin errors++; $display("FAIL pri_wben: got %b want 1", writeBackEn); end
        checks++; if (Result_WB !== 32'h0000_BEEF) begin errors++; $display("FAIL pri_result: got %h want beef", Result_WB); end
        checks++; if (Dest_wb !== 4'd6) begin errors++; $display("FAIL pri_dest: got %h want 6", Dest_wb); end
        tick();
    endtask

    // ALU_Res = 3: (3 - 1024) wraps to 0xFFFFFC03, >>2 = 0x3FFFFF00, low 16 bits 0xFF00.
    task automatic test_addr_wrap();
        set_in(1'b0, 1'b0, 1'b1, 32'd3, 32'h0000_5A5A, 4'd0);
        tick(); mem_ack = 1'b1; mid();
        checks++; if (mem_addr !== 16'hFF00) begin errors++; $display("FAIL wrap_addr: got %h want ff00", mem_addr); end
        checks++; if (mem_wdata !== 32'h0000_5A5A) begin errors++; $display("FAIL wrap_wdata: got %h want 5a5a", mem_wdata); end
        tick(); mem_ack = 1'b0; bubble(); mid();
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL wrap_wben: got %b want 0", writeBackEn); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wrap_req: got %b want 0", mem_req); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd2);
        tick(); mid();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_req_before: got %b want 1", mem_req); end
        RST = 1'b1;
        tick(); RST = 1'b0; bubble(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; mid();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", mem_req); end
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL rmid_wben: got %b want 0", writeBackEn); end
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rmid_freeze: got %b want 0", freeze); end
        tick(); mem_ack = 1'b0; mem_rdata = 32'h0; mid();
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL rmid_late_wben: got %b want 0", writeBackEn); end
        checks++; if (Result_WB !== 32'h0) begin errors++; $display("FAIL rmid_late_result: got %h want 0", Result_WB); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmid_late_req: got %b want 0", mem_req); end
        tick();
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        set_in(1'b1, 1'b0, 1'b0, 32'h0000_0099, 32'h0, 4'd1);
        tick();
        set_in(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'd5);
        tick();
        for (int i = 0; i < 3; i++) begin
            mid();
            checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL to_freeze[%0d]: got %b want 1", i, freeze); end
            checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_err_early[%0d]: got %b want 0", i, mem_err); end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL to_req[%0d]: got %b want 1", i, mem_req); end
            tick();
        end
        mid();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_err_last: got %b want 0", mem_err); end
        tick(); bubble(); mid();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", mem_err); end
        checks++; if (writeBackEn !== 1'b1) begin errors++; $display("FAIL to_wben: got %b want 1", writeBackEn); end
        checks++; if (Dest_wb !== 4'd5) begin errors++; $display("FAIL to_dest: got %h want 5", Dest_wb); end
        checks++; if (Result_WB !== 32'h0) begin errors++; $display("FAIL to_result: got %h want 0", Result_WB); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL to_req_done: got %b want 0", mem_req); end
        tick(); mid();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b want 0", mem_err); end
        checks++; if (writeBackEn !== 1'b0) begin errors++; $display("FAIL to_wben_once: got %b want 0", writeBackEn); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_store();
        test_load();
        test_back_to_back();
        test_priority();
        test_addr_wrap();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
